// File: rtl/comparator_seq_if.sv
// Handshake bundle for the serial comparator: request side (a/b/mode) and result side.
// The master drives requests and consumes results; the slave is the comparator itself.
interface comparator_seq_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [2:0]   mode;
  logic         out_valid;
  logic         out_ready;
  logic         result;
  logic         eq;
  logic         lt;
  logic         err;

  modport master (
    output in_valid, a, b, mode, out_ready,
    input  in_ready, out_valid, result, eq, lt, err
  );

  modport slave (
    input  in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, result, eq, lt, err
  );
endinterface

// File: rtl/comparator_seq.sv
// Serial magnitude/equality comparator: W bits per cycle, MSB slice first,
// finishing at the first differing slice. One transaction in flight.
module comparator_seq #(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  comparator_seq_if.slave  bus
);
  localparam int S  = N / W;
  localparam int CW = (S > 1) ? $clog2(S) : 1;

  if (N % W != 0) begin : g_bad_width
    $error("comparator_seq: N must be a multiple of W");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  state_t         r_state;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic [2:0]     r_mode;
  logic [CW-1:0]  r_idx;
  logic           r_in_ready;
  logic           r_out_valid;
  logic           r_result;
  logic           r_eq;
  logic           r_lt;
  logic           r_err;

  logic [W-1:0]   w_sa [S];
  logic [W-1:0]   w_sb [S];
  logic [W-1:0]   w_cur_a;
  logic [W-1:0]   w_cur_b;
  logic           w_diff;
  logic           w_last;
  logic           w_eq_n;
  logic           w_lt_n;
  logic           w_sgn;
  logic [N-1:0]   w_sgn_mask;

  for (genvar gi = 0; gi < S; gi++) begin : g_slice
    assign w_sa[gi] = r_a[gi*W +: W];
    assign w_sb[gi] = r_b[gi*W +: W];
  end

  assign w_cur_a = w_sa[r_idx];
  assign w_cur_b = w_sb[r_idx];
  assign w_diff  = (w_cur_a != w_cur_b);
  assign w_last  = (r_idx == '0);
  assign w_eq_n  = !w_diff;
  assign w_lt_n  = w_diff && (w_cur_a < w_cur_b);

  // Flipping both sign bits maps two's-complement order onto unsigned order.
  assign w_sgn      = (bus.mode[2:1] == 2'b10);
  assign w_sgn_mask = {w_sgn, {(N-1){1'b0}}};

  function automatic logic f_result(input logic [2:0] m, input logic e, input logic l);
    logic res;
    case (m)
      3'b000:         res = e;
      3'b001:         res = !e;
      3'b100, 3'b110: res = l;
      3'b101, 3'b111: res = !l;
      default:        res = 1'b0;
    endcase
    return res;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_mode      <= '0;
      r_idx       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= 1'b0;
      r_eq        <= 1'b0;
      r_lt        <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_a        <= bus.a ^ w_sgn_mask;
            r_b        <= bus.b ^ w_sgn_mask;
            r_mode     <= bus.mode;
            r_idx      <= CW'(S - 1);
            r_in_ready <= 1'b0;
            r_state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_diff || w_last) begin
            r_eq        <= w_eq_n;
            r_lt        <= w_lt_n;
            r_result    <= f_result(r_mode, w_eq_n, w_lt_n);
            r_err       <= (r_mode[2:1] == 2'b01);
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.eq        = r_eq;
  assign bus.lt        = r_lt;
  assign bus.err       = r_err;
endmodule
